// File: rtl/dmem_lsu.sv
// dmem_lsu: turns MIPS32 byte/halfword/word loads and stores into word-only
// dmem transactions. Sub-word stores use a read-modify-write pass. Loads are
// lane-selected and sign/zero extended. Misaligned, out-of-range and
// reserved-size requests complete immediately with err set.
module dmem_lsu #(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_wd_q, mem_wd_d;
  logic              acc_err_s;

  // Reserved size, misalignment for the access size, or a word index past the end of dmem.
  function automatic logic addr_error(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
    logic e;
    case (sz)
      2'b00:   e = 1'b0;
      2'b01:   e = a[0];
      2'b10:   e = |a[1:0];
      default: e = 1'b1;
    endcase
    if ({2'b00, a[31:2]} >= 32'(MEM_WORDS)) begin
      e = 1'b1;
    end else begin
      e = e;
    end
    return e;
  endfunction

  // Select the addressed byte/halfword lane and extend it; words pass straight through.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] sz, input logic unsign);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (sz)
      2'b00:   r = unsign ? {24'h00_0000, b} : {{24{b[7]}}, b};
      2'b01:   r = unsign ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane(s) of the old word with the store-data LSBs.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                              input logic [1:0] lane, input logic [1:0] sz);
    logic [31:0] mask;
    logic [31:0] ins;
    case (sz)
      2'b00: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        ins  = {4{data[7:0]}};
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        ins  = {2{data[15:0]}};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ins  = data;
      end
    endcase
    return (word & ~mask) | (ins & mask);
  endfunction

  assign acc_err_s = addr_error(addr, size);

  // Next-state and captured-register updates; live CPU inputs only matter in IDLE.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    mem_wd_d = mem_wd_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wr_d    = wr;
          size_d  = size;
          uns_d   = uns;
          wdata_d = wdata;
          err_d   = acc_err_s;
          if (acc_err_s) begin
            state_d = S_DONE;
          end else if (wr && (size == 2'b10)) begin
            mem_wd_d = wdata;
            state_d  = S_WR;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (wr_q) begin
          mem_wd_d = store_merge(mem_rd, wdata_q, addr_q[1:0], size_q);
          state_d  = S_WR;
        end else begin
          rdata_d = load_extract(mem_rd, addr_q[1:0], size_q, uns_q);
          state_d = S_DONE;
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured registers; async reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      wdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      mem_wd_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      mem_wd_q <= mem_wd_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = (state_q == S_DONE) && err_q;
  assign mem_re = (state_q == S_RD);
  assign mem_we = (state_q == S_WR);
  assign mem_a  = {addr_q[31:2], 2'b00};
  assign mem_wd = mem_wd_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a word memory answers the dmem port, a transaction-level
// model predicts every cycle's outputs, and directed operations exercise loads,
// stores, error cases, mid-operation reset and back-to-back requests.
module tb_dmem_lsu;

  localparam int MEM_WORDS = 64;

  logic        clk, rst_n, req, wr, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_we, mem_re;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  dmem_lsu #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_we(mem_we), .mem_re(mem_re), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Data memory seen by the DUT
  logic [31:0] dmem [MEM_WORDS];
  assign mem_rd = mem_re ? dmem[mem_a[7:2]] : 32'hzzzz_zzzz;
  always @(posedge clk) if (mem_we) dmem[mem_a[7:2]] <= mem_wd;

  // Reference model state
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] model_rdata;
  logic        chk_en;
  logic        cur_live, cur_wr, cur_uns, cur_err;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;
  int          cur_k, cur_lat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_err(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    if ((a / 4) >= MEM_WORDS) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                         input logic [1:0] sz, input logic u);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'h0000_00FF;
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * ((a % 4) / 2))) & 32'h0000_FFFF;
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] a,
                                          input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    int base, nb;
    r = w;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = (sz == 2'd0) ? int'(a % 4) : (sz == 2'd1) ? int'(a % 4) / 2 * 2 : 0;
    for (int i = 0; i < nb; i++) begin
      r[8*(base+i) +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  // Single compare process: every cycle, check outputs against the model's view of the current transaction
  always @(negedge clk) begin
    if (chk_en) begin
      if (cur_live) begin
        logic re_e, we_e, done_e;
        int idx;
        idx    = int'(cur_addr[7:2]);
        done_e = (cur_k == cur_lat);
        re_e   = 1'b0;
        we_e   = 1'b0;
        if (!cur_err) begin
          if (!cur_wr) re_e = (cur_k == 1);
          else if (cur_size == 2'd2) we_e = (cur_k == 1);
          else begin
            re_e = (cur_k == 1);
            we_e = (cur_k == 2);
          end
        end
        check("busy", {31'd0, busy}, {31'd0, cur_k != 0});
        check("done", {31'd0, done}, {31'd0, done_e});
        check("mem_re", {31'd0, mem_re}, {31'd0, re_e});
        check("mem_we", {31'd0, mem_we}, {31'd0, we_e});
        if (re_e || we_e) check("mem_a", mem_a, {cur_addr[31:2], 2'b00});
        if (we_e) check("mem_wd", mem_wd, m_store(ref_mem[idx], cur_addr, cur_size, cur_wdata));
        if (done_e) begin
          check("err", {31'd0, err}, {31'd0, cur_err});
          if (!cur_err) begin
            if (cur_wr) ref_mem[idx] = m_store(ref_mem[idx], cur_addr, cur_size, cur_wdata);
            else model_rdata = m_load(ref_mem[idx], cur_addr, cur_size, cur_uns);
          end
          check("mem_word", dmem[idx], ref_mem[idx]);
        end
        check("rdata", rdata, model_rdata);
        cur_k++;
        if (cur_k > cur_lat) cur_live = 1'b0;
      end else begin
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_mem", {30'd0, mem_re, mem_we}, 32'd0);
        check("idle_rdata", rdata, model_rdata);
      end
    end
  end

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input logic hold);
    int lat;
    logic e;
    e   = m_err(a, sz);
    lat = e ? 1 : ((!w || sz == 2'd2) ? 2 : 3);
    cur_wr = w; cur_size = sz; cur_uns = u; cur_addr = a; cur_wdata = d;
    cur_err = e; cur_lat = lat; cur_k = 0; cur_live = 1'b1;
    req = 1'b1; wr = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk); #1;
    if (hold) begin
      addr  = 32'h0000_0038;
      wdata = 32'hDEAD_BEEF;
    end else begin
      req = 1'b0;
    end
    repeat (lat) @(posedge clk);
    #1;
  endtask

  initial begin
    chk_en = 1'b0; cur_live = 1'b0; cur_k = 0; cur_lat = 0;
    cur_wr = 1'b0; cur_size = 2'd0; cur_uns = 1'b0; cur_err = 1'b0;
    cur_addr = 32'd0; cur_wdata = 32'd0; model_rdata = 32'd0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      dmem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; uns = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_mem", {30'd0, mem_re, mem_we}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Word store and load back
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hA1B2_C3D4, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
    check("t1_word8", dmem[8], 32'hA1B2_C3D4);
    check("t1_rdata", rdata, 32'hA1B2_C3D4);

    // Byte store by read-modify-write
    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_007E, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
    check("t2_word8", dmem[8], 32'hA1B2_7ED4);
    check("t2_rdata", rdata, 32'hA1B2_7ED4);

    // Sub-word loads with extension, plus a halfword store
    issue(1'b1, 2'd2, 1'b0, 32'h24, 32'h80F0_1234, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h27, 32'h0, 1'b0);
    check("t3_lb", rdata, 32'hFFFF_FF80);
    issue(1'b0, 2'd0, 1'b1, 32'h27, 32'h0, 1'b0);
    check("t3_lbu", rdata, 32'h0000_0080);
    issue(1'b0, 2'd1, 1'b0, 32'h26, 32'h0, 1'b0);
    check("t3_lh", rdata, 32'hFFFF_80F0);
    issue(1'b0, 2'd1, 1'b1, 32'h24, 32'h0, 1'b0);
    check("t3_lhu", rdata, 32'h0000_1234);
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_BEEF, 1'b0);
    check("t3_sh", dmem[8], 32'hBEEF_7ED4);

    // Error requests: rdata must stay at the last load result
    issue(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h22, 32'h5555_5555, 1'b0);
    issue(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'(MEM_WORDS * 4), 32'h0, 1'b0);
    check("t4_rdata", rdata, 32'h0000_1234);
    check("t4_word8", dmem[8], 32'hBEEF_7ED4);

    // Reset during the write phase of a byte store
    issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h1122_3344, 1'b0);
    chk_en = 1'b0;
    req = 1'b1; wr = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h30; wdata = 32'h0000_0055;
    @(posedge clk); #1;
    req = 1'b0;
    check("t5_rd_phase", {31'd0, mem_re}, 32'd1);
    @(posedge clk); #1;
    check("t5_wr_phase", {31'd0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_we_drop", {31'd0, mem_we}, 32'd0);
    check("t5_busy_drop", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_word12", dmem[12], 32'h1122_3344);
    check("t5_done", {31'd0, done}, 32'd0);
    model_rdata = 32'd0;
    chk_en = 1'b1;

    // Held request: one accepted load every three cycles, addr changes while busy ignored
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
    check("t6_rdata", rdata, 32'hBEEF_7ED4);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator sitting between the MIPS32 execute/memory stage and the word-only data memory (`dmem`).
- Turns CPU byte, halfword and word loads and stores into `dmem` word transactions on its `we`/`re`/`a`/`wd`/`rd` interface.
- Sub-word stores use read-modify-write.
- Provides sign/zero extension for loads, plus alignment and range checking.

Parameters:
- MEM_WORDS, 64: number of 32-bit words in `dmem`. A word index >= MEM_WORDS is an error.
- ADDR_W, 32: CPU byte-address width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  CPU request strobe; sampled only in IDLE.
- wr  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (error).
- uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  ADDR_W  CPU byte address.
- wdata  in  32  store data; the sub-word value is taken from the LSBs.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only with done; misaligned access, out-of-range address or reserved size.
- rdata  out  32  extended load result; held until the next accepted load.
- mem_we  out  1  to `dmem` `we`.
- mem_re  out  1  to `dmem` `re`.
- mem_a  out  32  to `dmem` `a`; always {addr_q[31:2], 2'b00}.
- mem_wd  out  32  to `dmem` `wd`.
- mem_rd  in  32  from `dmem` `rd`; combinational, high-Z when mem_re = 0.

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE.
  - busy, done, err, mem_we, mem_re = 0.
  - rdata, mem_wd, and the captured addr/wdata/size/uns/wr registers = 0.
- FSM states: IDLE, RD, WR, DONE.
- Outputs decoded purely from the state register and captured registers, never from live CPU inputs:
  - mem_re = (state == RD).
  - mem_we = (state == WR).
- Request acceptance:
  - In IDLE with req = 1: capture addr, wr, size, uns, wdata on the edge.
  - req while busy is ignored; the CPU must hold it or re-issue after done.
- Error check at acceptance:
  - Error if size == 11, or size == 01 with addr[0] = 1, or size == 10 with addr[1:0] != 0, or addr[31:2] >= MEM_WORDS.
  - On error: go directly to DONE with err = 1. mem_re and mem_we never assert; rdata is unchanged.
- Transitions:
  - Load: IDLE -> RD -> DONE. mem_rd is captured at the RD->DONE edge.
  - Store word: IDLE -> WR -> DONE.
  - Store byte or halfword: IDLE -> RD -> WR -> DONE.
  - DONE -> IDLE unconditionally.
- Latency, counting from the accepting edge E:
  - Load: done is high in cycle E+2.
  - Store word: done is high in cycle E+2.
  - Sub-word store: done is high in cycle E+3.
  - Error: done is high in cycle E+1.
- Byte lanes are little-endian: byte k = bits [8k+7:8k] with k = addr[1:0]; halfword at bits [16h+15:16h] with h = addr[1].
- Load extraction: select the byte or halfword lane, then sign- or zero-extend per uns. Word loads are passed through.
- Store merge: in WR, mem_wd = captured word with only the addressed lane(s) replaced by the wdata LSBs. All other lanes are preserved bit-exact.
- Store word: mem_wd = wdata.
- rdata updates only on a successful load; stores and errors leave it unchanged.
- Reset mid-operation:
  - mem_we drops immediately; any pending WR is abandoned and the memory word is unchanged.
  - No done pulse is produced for the abandoned request.
- done and req in the same cycle: the request is not accepted (state is DONE). It is accepted in the following IDLE cycle if req is still high.

Test Plan:
1. Reset, then sw addr=0x20 wdata=0xA1B2C3D4; then lw addr=0x20 -> mem_we high for exactly 1 cycle at word index 8; lw done at E+2 with rdata=0xA1B2C3D4, err=0.
2. Word 0x20=0xA1B2C3D4; sb addr=0x21 wdata=0x0000007E -> RD then WR; mem_wd=0xA1B27ED4; a following lw returns 0xA1B27ED4; done at E+3.
3. Word 0x24=0x80F0_1234. lb addr=0x27 uns=0 -> 0xFFFFFF80; lbu addr=0x27 -> 0x00000080; lh addr=0x26 -> 0xFFFF80F0; lhu addr=0x24 -> 0x00001234.
4. lh addr=0x21; sw addr=0x22; size=11; lw addr=MEM_WORDS*4 -> each gives done with err=1 at E+1; mem_re and mem_we stay 0; rdata is unchanged.
5. sb addr=0x30 with rst_n pulsed low during the WR cycle -> mem_we falls asynchronously, no done, word 0x30 keeps its prior value, FSM is in IDLE after release.
6. Hold req=1 continuously issuing lw 0x20 -> requests accepted every 3 cycles; busy high 2 of every 3 cycles; changes to addr while busy have no effect.
